pc_update_unit: RTL and testbench
=================================

Name: pc_update_unit

Overview:
- Consumer end of the branch-offset path: takes the sign-extended, left-shifted 32-bit byte offset and the branch/jump controls.
- Maintains the program counter register and computes PC+4 and the branch/jump target.
- Holds the PC while memory asserts BUSYWAIT and commits a captured decision once the stall clears.
- Sits between the control unit / offset shifter and the instruction memory address input.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- CTRL_VALID  input  1  current instruction retires this cycle; control and offset inputs are valid.
- JUMP  input  1  unconditional jump.
- BRANCH_EQ  input  1  branch if ZERO=1.
- BRANCH_NE  input  1  branch if ZERO=0.
- ZERO  input  1  ALU zero flag.
- OFFSET  input  32  signed byte offset, already extended and shifted left 2.
- BUSYWAIT  input  1  memory stall request.
- PC  output  32  registered program counter.
- PC_PLUS4  output  32  combinational PC+4.
- REDIRECT  output  1  one-cycle pulse: PC was just loaded with a taken target.
- STALLED  output  1  high while in HOLD.
- ERROR  output  1  sticky protocol/alignment error.
- RETIRED  output  CNT_W  count of committed instructions.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RESET), sampled on the CLK rising edge; RESET has priority over every other event.
- Reset values: PC=RESET_PC, REDIRECT=0, STALLED=0, ERROR=0, RETIRED=0, state=RUN, pending registers cleared.
- Arithmetic:
  - PC_PLUS4 = PC+4, modulo 2^32.
  - TARGET = PC_PLUS4 + OFFSET, two's complement, modulo 2^32, wrap permitted.
- Taken decision: TAKEN = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO).
  - JUMP has priority; the result is identical regardless.
  - BRANCH_EQ and BRANCH_NE both set with no JUMP: TAKEN=1 for either ZERO value, which is legal.
- Alignment: if TAKEN and OFFSET[1:0]≠0, set ERROR, treat as not taken (NEXT=PC_PLUS4), no REDIRECT.
- NEXT = TAKEN ? TARGET : PC_PLUS4.
- State RUN:
  - CTRL_VALID=0: PC holds, nothing changes.
  - CTRL_VALID=1, BUSYWAIT=0: PC<=NEXT, RETIRED+=1, REDIRECT<=TAKEN (after the alignment rule). Stay RUN. Latency 1 cycle.
  - CTRL_VALID=1, BUSYWAIT=1: PEND_PC<=NEXT, PEND_TAKEN<=TAKEN, go HOLD. PC unchanged.
- State HOLD (STALLED=1):
  - BUSYWAIT=1: hold everything.
  - BUSYWAIT=0: PC<=PEND_PC, REDIRECT<=PEND_TAKEN, RETIRED+=1, go RUN.
  - CTRL_VALID=1 in HOLD: input ignored, ERROR<=1. The pending value is preserved.
- REDIRECT is 0 on every cycle other than the one following a taken commit.
- RETIRED wraps at 2^CNT_W-1 to 0.
- ERROR clears only on RESET.
- RESET asserted while in HOLD: the pending value is discarded and the reset values above are applied.

Decomposition:
- Shared package pc_pkg holds:
  - state encoding (RUN=1'b0, HOLD=1'b1);
  - PC_STEP=4;
  - the default for RESET_PC.
- Optional sub-module next_pc_calc, combinational: produces PC_PLUS4, TARGET, TAKEN, and the misalignment flag. The FSM and registers stay in the top module.

Test Plan:
- Reset then 3 retirements, no branches, BUSYWAIT=0 -> PC 0→4→8→12, RETIRED=3, REDIRECT never high.
- PC=8, BRANCH_EQ=1, ZERO=1, OFFSET=32'hFFFF_FFF8 (−8) -> next PC=4, REDIRECT pulse of exactly one cycle. Same stimulus with ZERO=0 -> PC=12, no pulse.
- PC=16, JUMP=1, OFFSET=40, BUSYWAIT=1 for 3 cycles -> STALLED high for 3 cycles, PC stays 16, then PC=60 with REDIRECT pulse, RETIRED+1. Extra CTRL_VALID during HOLD -> ERROR=1, PC still 60.
- PC=32'hFFFF_FFF8, JUMP=1, OFFSET=8 -> PC=32'h0000_0004 (wrap). Second case: OFFSET=6 -> ERROR=1, PC=32'hFFFF_FFFC, no REDIRECT.
- RESET asserted during HOLD with a pending taken jump -> next cycle PC=RESET_PC, STALLED=0, ERROR=0, RETIRED=0, no REDIRECT.
- CNT_W=4, 17 retirements -> RETIRED=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter update path.
// FSM encoding, PC step size and default reset vector.
package pc_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } pc_state_e;

  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC arithmetic: PC+4, branch target,
// taken decision and target misalignment flag.
module next_pc_calc
  import pc_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        jump_i,
  input  logic        beq_i,
  input  logic        bne_i,
  input  logic        zero_i,
  input  logic [31:0] offset_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] target_o,
  output logic        taken_o,
  output logic        misalign_o
);

  assign pc_plus4_o = pc_i + PC_STEP;
  assign target_o   = pc_plus4_o + offset_i;

  // BEQ and BNE together cover both ZERO values, so that pair is always taken.
  assign taken_o = jump_i
                 | (beq_i & zero_i)
                 | (bne_i & ~zero_i);

  assign misalign_o = taken_o & (offset_i[1:0] != 2'b00);

endmodule

// File: rtl/pc_update_unit.sv
// Program counter register with branch/jump redirect, memory-stall
// hold of the captured decision, sticky error and retire counter.
module pc_update_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CTRL_VALID,
  input  logic             JUMP,
  input  logic             BRANCH_EQ,
  input  logic             BRANCH_NE,
  input  logic             ZERO,
  input  logic [31:0]      OFFSET,
  input  logic             BUSYWAIT,
  output logic [31:0]      PC,
  output logic [31:0]      PC_PLUS4,
  output logic             REDIRECT,
  output logic             STALLED,
  output logic             ERROR,
  output logic [CNT_W-1:0] RETIRED
);

  pc_state_e        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic             pend_tk_q, pend_tk_d;
  logic             redir_q, redir_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic [31:0] plus4;
  logic [31:0] target;
  logic        taken;
  logic        misalign;
  logic        take_ok;
  logic [31:0] next_pc;

  next_pc_calc u_calc (
    .pc_i       (pc_q),
    .jump_i     (JUMP),
    .beq_i      (BRANCH_EQ),
    .bne_i      (BRANCH_NE),
    .zero_i     (ZERO),
    .offset_i   (OFFSET),
    .pc_plus4_o (plus4),
    .target_o   (target),
    .taken_o    (taken),
    .misalign_o (misalign)
  );

  // A misaligned target degrades to a sequential step.
  assign take_ok = taken & ~misalign;
  assign next_pc = take_ok ? target : plus4;

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (CTRL_VALID && BUSYWAIT) state_d = HOLD;
      HOLD:    if (!BUSYWAIT) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    STALLED = (state_q == HOLD);
  end

  always_comb begin
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    pend_tk_d = pend_tk_q;
    redir_d   = 1'b0;
    err_d     = err_q;
    ret_d     = ret_q;
    unique case (state_q)
      RUN: begin
        if (CTRL_VALID) begin
          if (misalign) err_d = 1'b1;
          if (BUSYWAIT) begin
            pend_pc_d = next_pc;
            pend_tk_d = take_ok;
          end else begin
            pc_d    = next_pc;
            redir_d = take_ok;
            ret_d   = ret_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        // A new instruction while stalled is a protocol violation.
        if (CTRL_VALID) err_d = 1'b1;
        if (!BUSYWAIT) begin
          pc_d    = pend_pc_q;
          redir_d = pend_tk_q;
          ret_d   = ret_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      pend_tk_q <= 1'b0;
      redir_q   <= 1'b0;
      err_q     <= 1'b0;
      ret_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      pend_tk_q <= pend_tk_d;
      redir_q   <= redir_d;
      err_q     <= err_d;
      ret_q     <= ret_d;
    end
  end

  assign PC       = pc_q;
  assign PC_PLUS4 = plus4;
  assign REDIRECT = redir_q;
  assign ERROR    = err_q;
  assign RETIRED  = ret_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed plus random checks of pc_update_unit against a
// transaction-level model of the PC, stall and counter rules.
module tb_pc_update_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CTRL_VALID = 1'b0;
  logic        JUMP = 1'b0;
  logic        BRANCH_EQ = 1'b0;
  logic        BRANCH_NE = 1'b0;
  logic        ZERO = 1'b0;
  logic [31:0] OFFSET = '0;
  logic        BUSYWAIT = 1'b0;

  logic [31:0] PC, PC_PLUS4, PC4, PC_PLUS4_4;
  logic        REDIRECT, STALLED, ERROR;
  logic        REDIRECT4, STALLED4, ERROR4;
  logic [15:0] RETIRED;
  logic [3:0]  RETIRED4;

  always #5 CLK = ~CLK;

  pc_update_unit dut (
    .CLK(CLK), .RESET(RESET), .CTRL_VALID(CTRL_VALID),
    .JUMP(JUMP), .BRANCH_EQ(BRANCH_EQ), .BRANCH_NE(BRANCH_NE),
    .ZERO(ZERO), .OFFSET(OFFSET), .BUSYWAIT(BUSYWAIT),
    .PC(PC), .PC_PLUS4(PC_PLUS4), .REDIRECT(REDIRECT),
    .STALLED(STALLED), .ERROR(ERROR), .RETIRED(RETIRED)
  );

  pc_update_unit #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .CTRL_VALID(CTRL_VALID),
    .JUMP(JUMP), .BRANCH_EQ(BRANCH_EQ), .BRANCH_NE(BRANCH_NE),
    .ZERO(ZERO), .OFFSET(OFFSET), .BUSYWAIT(BUSYWAIT),
    .PC(PC4), .PC_PLUS4(PC_PLUS4_4), .REDIRECT(REDIRECT4),
    .STALLED(STALLED4), .ERROR(ERROR4), .RETIRED(RETIRED4)
  );

  int n_assert = 0;
  int n_fail = 0;

  // Reference model state: architectural view only.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_pend = 32'h0;
  bit          m_pend_tk = 0;
  bit          m_held = 0;
  bit          m_err = 0;
  bit          m_redir = 0;
  int unsigned m_ret = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic [31:0] p4, nxt;
    bit tk, mis;
    if (RESET) begin
      m_pc = 32'h0; m_held = 0; m_err = 0;
      m_ret = 0; m_redir = 0; m_pend = 0; m_pend_tk = 0;
      return;
    end
    p4  = m_pc + 32'd4;
    tk  = JUMP || (BRANCH_EQ && ZERO) || (BRANCH_NE && !ZERO);
    mis = tk && (OFFSET % 4 != 0);
    if (mis) tk = 0;
    nxt = tk ? p4 + OFFSET : p4;
    m_redir = 0;
    if (!m_held) begin
      if (CTRL_VALID) begin
        if (mis) m_err = 1;
        if (BUSYWAIT) begin
          m_pend = nxt; m_pend_tk = tk; m_held = 1;
        end else begin
          m_pc = nxt; m_redir = tk; m_ret++;
        end
      end
    end else begin
      if (CTRL_VALID) m_err = 1;
      if (!BUSYWAIT) begin
        m_pc = m_pend; m_redir = m_pend_tk; m_ret++; m_held = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("pc", PC, m_pc);
    chk("pc_plus4", PC_PLUS4, m_pc + 32'd4);
    chk("redirect", 32'(REDIRECT), 32'(m_redir));
    chk("stalled", 32'(STALLED), 32'(m_held));
    chk("error", 32'(ERROR), 32'(m_err));
    chk("retired", 32'(RETIRED), 32'(m_ret % 65536));
    chk("retired4", 32'(RETIRED4), 32'(m_ret % 16));
  endtask

  task automatic step(bit rst, bit cv, bit j, bit beq, bit bne,
                      bit z, logic [31:0] off, bit bw);
    RESET = rst; CTRL_VALID = cv; JUMP = j;
    BRANCH_EQ = beq; BRANCH_NE = bne; ZERO = z;
    OFFSET = off; BUSYWAIT = bw;
    model_update();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic retire();
    step(0, 1, 0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic goto(logic [31:0] addr);
    step(0, 1, 1, 0, 0, 0, addr - m_pc - 32'd4, 0);
  endtask

  initial begin
    do_reset();
    chk("reset_pc", PC, 32'h0);
    chk("reset_ret", 32'(RETIRED), 32'h0);

    repeat (3) begin
      retire();
      chk("seq_noredir", 32'(REDIRECT), 32'h0);
    end
    chk("seq_pc12", PC, 32'd12);
    chk("seq_ret3", 32'(RETIRED), 32'd3);

    goto(32'd8);
    step(0, 1, 0, 1, 0, 1, 32'hFFFF_FFF8, 0);
    chk("beq_pc", PC, 32'd4);
    chk("beq_redir", 32'(REDIRECT), 32'h1);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0);
    chk("beq_pulse_end", 32'(REDIRECT), 32'h0);
    goto(32'd8);
    step(0, 1, 0, 1, 0, 0, 32'hFFFF_FFF8, 0);
    chk("beq_nt_pc", PC, 32'd12);
    chk("beq_nt_redir", 32'(REDIRECT), 32'h0);

    goto(32'd16);
    step(0, 1, 1, 0, 0, 0, 32'd40, 1);
    repeat (2) begin
      chk("hold_stalled", 32'(STALLED), 32'h1);
      chk("hold_pc", PC, 32'd16);
      step(0, 0, 0, 0, 0, 0, 32'h0, 1);
    end
    chk("hold_stalled3", 32'(STALLED), 32'h1);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0);
    chk("jump_pc60", PC, 32'd60);
    chk("jump_redir", 32'(REDIRECT), 32'h1);
    chk("jump_unstall", 32'(STALLED), 32'h0);
    step(0, 1, 0, 0, 0, 0, 32'h0, 1);
    step(0, 1, 1, 0, 0, 0, 32'd100, 1);
    chk("cv_in_hold_err", 32'(ERROR), 32'h1);
    chk("cv_in_hold_pc", PC, 32'd60);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0);
    chk("pend_kept", PC, 32'd64);

    do_reset();
    goto(32'hFFFF_FFF8);
    step(0, 1, 1, 0, 0, 0, 32'd8, 0);
    chk("wrap_pc", PC, 32'h0000_0004);
    goto(32'hFFFF_FFF8);
    step(0, 1, 1, 0, 0, 0, 32'd6, 0);
    chk("misal_err", 32'(ERROR), 32'h1);
    chk("misal_pc", PC, 32'hFFFF_FFFC);
    chk("misal_redir", 32'(REDIRECT), 32'h0);

    step(0, 1, 1, 0, 0, 0, 32'd40, 1);
    step(1, 0, 0, 0, 0, 0, 32'h0, 1);
    chk("rst_hold_pc", PC, 32'h0);
    chk("rst_hold_stall", 32'(STALLED), 32'h0);
    chk("rst_hold_err", 32'(ERROR), 32'h0);
    chk("rst_hold_ret", 32'(RETIRED), 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0);
    chk("rst_hold_noredir", 32'(REDIRECT), 32'h0);
    chk("rst_hold_pc2", PC, 32'h0);

    do_reset();
    repeat (17) retire();
    chk("cnt4_wrap", 32'(RETIRED4), 32'd1);

    do_reset();
    repeat (400) begin
      logic [31:0] off;
      off = 32'($signed($urandom_range(0, 64)) - 32) << 2;
      if ($urandom_range(0, 7) == 0) off = off | 32'($urandom_range(1, 3));
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1,
           off,
           $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
